// File: rtl/register_file_mp_pkg.sv
// Shared types for the multi-port register file: default size, clear-engine
// state encoding and a register index type.
package common;

  localparam int unsigned REGISTER_FILE_SIZE = 32;

  typedef enum logic {RF_IDLE, RF_CLEAR} rf_clr_state_t;

  typedef logic [$clog2(REGISTER_FILE_SIZE)-1:0] reg_id_t;

endpackage

// File: rtl/register_file_mp_if.sv
// Bundle of write, read, scoreboard and clear signals between the decode/writeback
// logic (master) and the register file (slave).
interface register_file_mp_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = common::REGISTER_FILE_SIZE,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  logic [NUM_WR-1:0]              wr_en;
  logic [NUM_WR-1:0][AW-1:0]      wr_id;
  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data;
  logic [NUM_RD-1:0][AW-1:0]      rd_id;
  logic [NUM_RD-1:0][DATA_W-1:0]  rd_data;
  logic [NUM_RD-1:0]              rd_ready;
  logic                           sb_set_en;
  logic [AW-1:0]                  sb_set_id;
  logic [NUM_REGS-1:0]            pending;
  logic                           clear_req;
  logic                           clear_busy;

  modport master (
    output wr_en, wr_id, wr_data, rd_id, sb_set_en, sb_set_id, clear_req,
    input  rd_data, rd_ready, pending, clear_busy
  );

  modport slave (
    input  wr_en, wr_id, wr_data, rd_id, sb_set_en, sb_set_id, clear_req,
    output rd_data, rd_ready, pending, clear_busy
  );

endinterface

// File: rtl/register_file_mp_rf_write_arbiter.sv
// For each queried register index, finds the highest-numbered effective write
// port targeting it and returns its data.
module rf_write_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned NUM_WR = 2,
  parameter int unsigned NUM_Q  = 2
) (
  input  logic [NUM_WR-1:0]             wr_eff_i,
  input  logic [NUM_WR-1:0][AW-1:0]     wr_id_i,
  input  logic [NUM_WR-1:0][DATA_W-1:0] wr_data_i,
  input  logic [NUM_Q-1:0][AW-1:0]      q_id_i,
  output logic [NUM_Q-1:0]              hit_o,
  output logic [NUM_Q-1:0][DATA_W-1:0]  data_o
);

  always_comb begin
    hit_o  = '0;
    data_o = '0;
    for (int q = 0; q < int'(NUM_Q); q++) begin
      // Ascending scan: a later (higher) port overrides earlier hits.
      for (int p = 0; p < int'(NUM_WR); p++) begin
        if (wr_eff_i[p] && (wr_id_i[p] == q_id_i[q])) begin
          hit_o[q]  = 1'b1;
          data_o[q] = wr_data_i[p];
        end
      end
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with write-to-read bypass, pending scoreboard and a
// sequential bulk-clear engine that zeroes one register per cycle.
module register_file_mp
  import common::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = REGISTER_FILE_SIZE,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input logic               clk,
  input logic               reset,
  register_file_mp_if.slave bus
);

  localparam int unsigned AW = $clog2(NUM_REGS);

  rf_clr_state_t                  state_q, state_d;
  logic [AW-1:0]                  cnt_q, cnt_d;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]            pend_q, pend_d;

  logic                           clear_busy;
  logic [NUM_WR-1:0]              wr_eff;
  logic                           sb_eff;
  logic [NUM_REGS-1:0][AW-1:0]    all_ids;
  logic [NUM_REGS-1:0]            reg_hit;
  logic [NUM_REGS-1:0][DATA_W-1:0] reg_wdata;
  logic [NUM_RD-1:0]              byp_hit;
  logic [NUM_RD-1:0][DATA_W-1:0]  byp_data;

  assign clear_busy = (state_q == RF_CLEAR);

  always_comb begin
    wr_eff = '0;
    for (int p = 0; p < int'(NUM_WR); p++) begin
      wr_eff[p] = bus.wr_en[p] & ~clear_busy & (!ZERO_REG || (bus.wr_id[p] != '0));
    end
    sb_eff = bus.sb_set_en & ~clear_busy & (!ZERO_REG || (bus.sb_set_id != '0));
  end

  always_comb begin
    all_ids = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      all_ids[i] = AW'(i);
    end
  end

  // Per-register resolution drives the array update.
  rf_write_arbiter #(
    .DATA_W (DATA_W),
    .AW     (AW),
    .NUM_WR (NUM_WR),
    .NUM_Q  (NUM_REGS)
  ) u_wr_arb (
    .wr_eff_i  (wr_eff),
    .wr_id_i   (bus.wr_id),
    .wr_data_i (bus.wr_data),
    .q_id_i    (all_ids),
    .hit_o     (reg_hit),
    .data_o    (reg_wdata)
  );

  // Per-read-port resolution drives the bypass.
  rf_write_arbiter #(
    .DATA_W (DATA_W),
    .AW     (AW),
    .NUM_WR (NUM_WR),
    .NUM_Q  (NUM_RD)
  ) u_byp_arb (
    .wr_eff_i  (wr_eff),
    .wr_id_i   (bus.wr_id),
    .wr_data_i (bus.wr_data),
    .q_id_i    (bus.rd_id),
    .hit_o     (byp_hit),
    .data_o    (byp_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RF_IDLE: begin
        if (bus.clear_req) begin
          state_d = RF_CLEAR;
          cnt_d   = '0;
        end
      end
      RF_CLEAR: begin
        // Counter parks at the terminal index rather than wrapping.
        if (cnt_q == AW'(NUM_REGS - 1)) begin
          state_d = RF_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RF_IDLE;
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (reg_hit[i]) begin
        regs_d[i] = reg_wdata[i];
        pend_d[i] = 1'b0;
      end
    end
    // Set is applied after write-clear so it wins on a same-id collision.
    if (sb_eff) begin
      pend_d[bus.sb_set_id] = 1'b1;
    end
    if (clear_busy) begin
      regs_d[cnt_q] = '0;
      pend_d[cnt_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RF_IDLE;
      cnt_q   <= '0;
      regs_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    bus.rd_data  = '0;
    bus.rd_ready = '0;
    for (int i = 0; i < int'(NUM_RD); i++) begin
      if (clear_busy) begin
        bus.rd_data[i] = '0;
      end else if (ZERO_REG && (bus.rd_id[i] == '0)) begin
        bus.rd_data[i] = '0;
      end else if (byp_hit[i]) begin
        bus.rd_data[i] = byp_data[i];
      end else begin
        bus.rd_data[i] = regs_q[bus.rd_id[i]];
      end
      bus.rd_ready[i] = ~clear_busy & (~pend_q[bus.rd_id[i]] | byp_hit[i]);
    end
  end

  assign bus.pending    = pend_q;
  assign bus.clear_busy = clear_busy;

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Multi-port, parametrised integer register file with write-to-read bypass, a per-register pending scoreboard and a sequenced bulk-clear engine. It sits in the decode stage of the core in place of the single-write, two-read register file. Decode uses `rd_ready` to stall on outstanding producers. Writeback drives up to `NUM_WR` retire ports per cycle.

## Interface
- `DATA_W`, 32, register width in bits
- `NUM_REGS`, 32, number of architectural registers (power of two, ≥ 4)
- `NUM_RD`, 2, number of read ports
- `NUM_WR`, 2, number of write ports
- `ZERO_REG`, 1, 1 = register 0 reads as zero and ignores writes and scoreboard sets
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears array, scoreboard and FSM
- `wr_en`  in  NUM_WR  per-port write enable
- `wr_id`  in  NUM_WR×AW  destination index (AW = $clog2(NUM_REGS))
- `wr_data`  in  NUM_WR×DATA_W  write data
- `rd_id`  in  NUM_RD×AW  source index
- `rd_data`  out  NUM_RD×DATA_W  read data (combinational)
- `rd_ready`  out  NUM_RD  source value valid (not pending, or bypassed this cycle)
- `sb_set_en`  in  1  mark `sb_set_id` pending (instruction issued with destination)
- `sb_set_id`  in  AW  register to mark pending
- `pending`  out  NUM_REGS  scoreboard bit vector
- `clear_req`  in  1  start sequential clear of all registers
- `clear_busy`  out  1  clear sequence in progress

## Operation
- Write: a port is effective when `wr_en[p]` is set, `clear_busy` is 0, and (`ZERO_REG`=0 or `wr_id[p]`≠0). An effective write updates the array at the next edge.
- Same-id write collision: the highest-numbered port wins for both the array update and the bypass.
- Read port i, evaluated in priority order:
  - `clear_busy` → 0
  - `ZERO_REG` and id 0 → 0
  - effective write to `rd_id[i]` this cycle → winning `wr_data`
  - otherwise the stored value
- Scoreboard:
  - `sb_set_en` sets `pending[sb_set_id]` (ignored for id 0 when `ZERO_REG`).
  - Any effective write to id k clears `pending[k]`.
  - If a set and a write hit the same id in the same cycle, the set wins and the bit ends at 1.
- `rd_ready[i]` = !`clear_busy` & (!`pending[rd_id[i]]` | effective write to `rd_id[i]` this cycle). A same-cycle `sb_set_en` does not affect `rd_ready` in that cycle.
- Clear FSM states: IDLE, CLEAR.
  - IDLE→CLEAR on `clear_req`. The counter loads 0.
  - In CLEAR, each cycle writes 0 to `registers[cnt]`, clears `pending[cnt]`, then increments `cnt`.
  - CLEAR→IDLE after writing index `NUM_REGS-1`.
  - `clear_req` while in CLEAR is ignored (no restart).
  - `sb_set_en` is ignored while `clear_busy`.

## Timing
- Reset values: array all 0, `pending` all 0, FSM IDLE, `clear_busy`=0. As a result `rd_data`=0 and `rd_ready`=1 for every port.
- Reset asserted mid-clear aborts the sequence immediately. All state returns to reset values.
- Read latency is 0 cycles (combinational through the bypass). A written value is stored one edge after `wr_en`.
- Scoreboard updates are visible on `pending` one cycle after `sb_set_en` or a write.
- `clear_busy` rises the cycle after `clear_req` is sampled and stays high for exactly `NUM_REGS` cycles.
- The first cycle after `clear_busy` falls accepts writes and sets normally.
- Counter width is AW bits. The terminal-count compare is against `NUM_REGS-1`, with no wrap to 0 in IDLE.

## Structure
- Package `common` holds:
  - `REGISTER_FILE_SIZE`, which remains the default source for `NUM_REGS` at instantiation
  - `typedef enum logic {RF_IDLE, RF_CLEAR} rf_clr_state_t`
  - `typedef logic [$clog2(REGISTER_FILE_SIZE)-1:0] reg_id_t`
- One sub-module, `rf_write_arbiter`: combinational; per read port, resolves the effective winning write (hit flag plus data). Used for both the bypass and the collision resolution.

## Test plan
- Reset, then read ids 0 and 5 → `rd_data`=0, `rd_ready`=1, `pending`=0.
- Write port0 id 3=0x11 and port1 id 3=0x22 in the same cycle, with read id 3 in that cycle → `rd_data`=0x22 that cycle. A read the next cycle returns 0x22.
- `sb_set_en` id 7; the next cycle reads id 7 → `rd_ready`=0. Port0 then writes id 7=0xAB → `rd_ready`=1 with `rd_data`=0xAB that cycle, and `pending[7]`=0 the next cycle.
- Same cycle: `sb_set_en` id 4 and write id 4 → `pending[4]`=1 the next cycle.
- Fill regs 1..31 with nonzero values, pulse `clear_req` → `clear_busy` high for 32 cycles, writes during clear dropped, all reads return 0 afterwards.
- Assert `reset` at clear cycle 10 → `clear_busy`=0 immediately and all `pending`=0. Write id 31=0x5 after reset → reads back 0x5.
